// File: rtl/instr_fetch_mem_if.sv
// Fetch-side bus between the fetch stage (master) and the instruction memory (slave).
//
// Handshake: a request transfers on a rising edge where req_valid & req_ready are
// both 1. The master must keep pc stable while req_valid=1 and req_ready=0. A
// response transfers on a rising edge where resp_valid & resp_ready are both 1. The
// slave holds resp_valid, resp_instr and resp_err stable until that edge.
interface instr_fetch_mem_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] pc;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_instr;
  logic [1:0]        resp_err;

  modport master (
    output req_valid, pc, resp_ready,
    input  req_ready, resp_valid, resp_instr, resp_err
  );

  modport slave (
    input  req_valid, pc, resp_ready,
    output req_ready, resp_valid, resp_instr, resp_err
  );
endinterface

// File: rtl/instr_fetch_mem.sv
// Word-organised instruction memory. The program is written over the load port
// while in LOAD; in RUN the fetch port returns one registered response per
// accepted PC. Misaligned, out-of-range and never-written fetches return
// ERR_INSTR with an error code instead of stale or aliased data.
module instr_fetch_mem #(
  parameter int          DEPTH_WORDS = 16,
  parameter int          ADDR_W      = 32,
  parameter logic [31:0] ERR_INSTR   = 32'h0000_0000,
  localparam int         CNT_W       = $clog2(DEPTH_WORDS) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_mode,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  output logic              in_load,
  output logic [CNT_W-1:0]  words_loaded,
  output logic [1:0]        dbg_state,
  instr_fetch_mem_if.slave  fetch
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  // Depth expressed at full word-index width so range checks never wrap.
  localparam logic [ADDR_W-3:0] DEPTH_IDX = (ADDR_W-2)'(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [31:0]            mem_q [DEPTH_WORDS];
  logic [DEPTH_WORDS-1:0] vld_q, vld_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_instr_q, resp_instr_d;
  logic [1:0]  resp_err_q, resp_err_d;

  logic [ADDR_W-3:0] ld_word, pc_word;
  logic [IDX_W-1:0]  ld_idx, pc_idx;
  logic              load_wr;
  logic              resp_free;
  logic              accept;
  logic [31:0]       fetch_instr;
  logic [1:0]        fetch_err;
  logic              unused_ld_lsb;

  // Byte address bits [1:0] of the load port carry no information.
  assign unused_ld_lsb = ^ld_addr[1:0];

  assign ld_word = ld_addr[ADDR_W-1:2];
  assign ld_idx  = ld_addr[IDX_W+1:2];
  assign pc_word = fetch.pc[ADDR_W-1:2];
  assign pc_idx  = fetch.pc[IDX_W+1:2];

  assign load_wr   = (state_q == S_LOAD) && ld_we && (ld_word < DEPTH_IDX);
  assign resp_free = !resp_valid_q || fetch.resp_ready;
  assign accept    = fetch.req_valid && fetch.req_ready;

  assign fetch.req_ready  = (state_q == S_RUN) && resp_free && !ld_mode;
  assign fetch.resp_valid = resp_valid_q;
  assign fetch.resp_instr = resp_instr_q;
  assign fetch.resp_err   = resp_err_q;
  assign in_load          = (state_q == S_LOAD);
  assign words_loaded     = cnt_q;
  assign dbg_state        = state_q;

  // Mode FSM: leave RUN only once no response is left stalled at the output.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:  if (!ld_mode) state_d = S_RUN;
      S_RUN:   if (ld_mode) state_d = resp_free ? S_LOAD : S_DRAIN;
      S_DRAIN: if (resp_free) state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_LOAD;
    else      state_q <= state_d;
  end

  // Instruction storage; contents survive reset, the valid bits gate reads.
  always_ff @(posedge clk) begin
    if (load_wr) mem_q[ld_idx] <= ld_data;
  end

  // Valid bits and distinct-word counter; rewrites of a valid word do not count.
  always_comb begin
    vld_d = vld_q;
    cnt_d = cnt_q;
    if (load_wr) begin
      vld_d[ld_idx] = 1'b1;
      if (!vld_q[ld_idx]) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Valid-bit and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
    end
  end

  // Error classification of the presented PC, highest priority first.
  always_comb begin
    fetch_err   = 2'b00;
    fetch_instr = mem_q[pc_idx];
    if (fetch.pc[1:0] != 2'b00) begin
      fetch_err   = 2'b01;
      fetch_instr = ERR_INSTR;
    end else if (pc_word >= DEPTH_IDX) begin
      fetch_err   = 2'b10;
      fetch_instr = ERR_INSTR;
    end else if (!vld_q[pc_idx]) begin
      fetch_err   = 2'b11;
      fetch_instr = ERR_INSTR;
    end
  end

  // Response next-state: load on accept, clear on consume, otherwise hold.
  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_instr_d = resp_instr_q;
    resp_err_d   = resp_err_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      resp_instr_d = fetch_instr;
      resp_err_d   = fetch_err;
    end else if (fetch.resp_ready) begin
      resp_valid_d = 1'b0;
    end
  end

  // Response registers; reset drops any pending response immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid_q <= 1'b0;
      resp_instr_q <= ERR_INSTR;
      resp_err_q   <= 2'b00;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_instr_q <= resp_instr_d;
      resp_err_q   <= resp_err_d;
    end
  end
endmodule
